// File: rtl/color_acc_pkg.sv
// Shared types and width helpers for the multi-channel region accumulator.
package color_acc_pkg;

    // Default geometry of the accumulator.
    localparam int unsigned DEF_PIX_W        = 8;
    localparam int unsigned DEF_CH           = 3;
    localparam int unsigned DEF_MAX_PIX_LOG2 = 15;

    // Controller states: accumulating, frozen by hold, result waiting for consumer.
    typedef enum logic [1:0] {
        ACC,
        HOLD,
        FLUSH
    } acc_state_t;

    // Lane sum width: wide enough for 2^max_pix_log2 full-scale samples.
    function automatic int unsigned acc_width(input int unsigned pix_w,
                                              input int unsigned max_pix_log2);
        return pix_w + max_pix_log2;
    endfunction

    // Pixel counter width: one extra bit so a full region count fits.
    function automatic int unsigned cnt_width(input int unsigned max_pix_log2);
        return max_pix_log2 + 1;
    endfunction

    // Base bit index of a lane inside a packed multi-lane bus.
    function automatic int unsigned lane_lo(input int unsigned lane,
                                            input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/color_acc_lane.sv
// One colour channel: running sum with saturate-or-wrap add and sticky overflow.
module color_acc_lane
    import color_acc_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned ACC_W = acc_width(DEF_PIX_W, DEF_MAX_PIX_LOG2),
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix,
    input  logic             add_en,
    input  logic             clr,
    output logic [ACC_W-1:0] sum_nxt,
    output logic             ovf_nxt
);

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   wide;

    // Sum including the current pixel; the carry bit is the overflow event.
    always_comb begin
        wide = {1'b0, acc_q} + (ACC_W+1)'(pix);
        if (SAT && wide[ACC_W]) begin
            sum_nxt = '1;
        end else begin
            sum_nxt = wide[ACC_W-1:0];
        end
        ovf_nxt = ovf_q | wide[ACC_W];
    end

    // Accumulator state: clear has priority over add.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (add_en) begin
            acc_q <= sum_nxt;
            ovf_q <= ovf_nxt;
        end
    end

endmodule

// File: rtl/color_accumulator_mc.sv
// Multi-channel region accumulator: per-lane sums, pixel count and overflow
// flags presented through a valid/ready result register.
module color_accumulator_mc
    import color_acc_pkg::*;
#(
    parameter int unsigned  PIX_W        = DEF_PIX_W,
    parameter int unsigned  CH           = DEF_CH,
    parameter int unsigned  MAX_PIX_LOG2 = DEF_MAX_PIX_LOG2,
    parameter bit           SAT          = 1'b1,
    localparam int unsigned ACC_W        = acc_width(PIX_W, MAX_PIX_LOG2),
    localparam int unsigned CNT_W        = cnt_width(MAX_PIX_LOG2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*PIX_W-1:0] pixel_in,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                hold,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*ACC_W-1:0] sum_out,
    output logic [CNT_W-1:0]    count_out,
    output logic [CH-1:0]       ovf_out
);

    acc_state_t          state;
    logic                accept;
    logic                lane_add;
    logic                lane_clr;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CH*ACC_W-1:0] sum_nxt_bus;
    logic [CH-1:0]       ovf_nxt_bus;

    assign in_ready = (state == ACC) && !hold;

    // Lane controls and saturating pixel count for the current edge.
    always_comb begin
        accept   = in_valid && in_ready;
        lane_add = accept && !in_last;
        // Lanes restart after a completed region or when a hold is released.
        lane_clr = (accept && in_last) || ((state == HOLD) && !hold);
        cnt_nxt  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        color_acc_lane #(
            .PIX_W (PIX_W),
            .ACC_W (ACC_W),
            .SAT   (SAT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .pix     (pixel_in[lane_lo(c, PIX_W) +: PIX_W]),
            .add_en  (lane_add),
            .clr     (lane_clr),
            .sum_nxt (sum_nxt_bus[lane_lo(c, ACC_W) +: ACC_W]),
            .ovf_nxt (ovf_nxt_bus[c])
        );
    end

    // Control FSM with pixel count and registered result/handshake outputs.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACC;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            count_out <= '0;
            ovf_out   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (hold) begin
                        state <= HOLD;
                    end else if (accept) begin
                        if (in_last) begin
                            sum_out   <= sum_nxt_bus;
                            count_out <= cnt_nxt;
                            ovf_out   <= ovf_nxt_bus;
                            out_valid <= 1'b1;
                            cnt_q     <= '0;
                            state     <= FLUSH;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                HOLD: begin
                    // Partial region is dropped; lanes clear via lane_clr.
                    if (!hold) begin
                        cnt_q <= '0;
                        state <= ACC;
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= hold ? HOLD : ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_accumulator_mc.sv
// Bench for color_accumulator_mc: three instances (default width, narrow
// saturating, narrow wrapping) share one stimulus stream and are compared
// against a plain-arithmetic region model.
module tb_color_accumulator_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_in;
    logic        in_valid, in_last, hold, out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [68:0] sum0;
    logic [26:0] sum1, sum2;
    logic [15:0] cnt0;
    logic [1:0]  cnt1, cnt2;
    logic [2:0]  ovf0, ovf1, ovf2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    color_accumulator_mc #(.PIX_W(8), .CH(3), .MAX_PIX_LOG2(15), .SAT(1'b1)) u_dut_def (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .hold(hold), .out_valid(ov0), .out_ready(out_ready),
        .sum_out(sum0), .count_out(cnt0), .ovf_out(ovf0)
    );

    color_accumulator_mc #(.PIX_W(8), .CH(3), .MAX_PIX_LOG2(1), .SAT(1'b1)) u_dut_sat (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .hold(hold), .out_valid(ov1), .out_ready(out_ready),
        .sum_out(sum1), .count_out(cnt1), .ovf_out(ovf1)
    );

    color_accumulator_mc #(.PIX_W(8), .CH(3), .MAX_PIX_LOG2(1), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy2), .hold(hold), .out_valid(ov2), .out_ready(out_ready),
        .sum_out(sum2), .count_out(cnt2), .ovf_out(ovf2)
    );

    // Reference model: per instance k and channel c
    int     accw[3] = '{23, 9, 9};
    int     cntw[3] = '{16, 2, 2};
    bit     satv[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3][3];
    bit     m_ovf[3][3];
    longint m_cnt[3];
    longint m_sum_o[3][3];
    bit     m_ovf_o[3][3];
    longint m_cnt_o[3];
    bit     m_full;    // a finished result is waiting for the consumer
    bit     m_frozen;  // region suspended by hold

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint dut_sum(input int k, input int c);
        case (k)
            0:       return longint'(sum0[c*23 +: 23]);
            1:       return longint'(sum1[c*9 +: 9]);
            default: return longint'(sum2[c*9 +: 9]);
        endcase
    endfunction

    function automatic longint dut_cnt(input int k);
        case (k)
            0:       return longint'(cnt0);
            1:       return longint'(cnt1);
            default: return longint'(cnt2);
        endcase
    endfunction

    function automatic longint dut_ovf(input int k, input int c);
        case (k)
            0:       return longint'(ovf0[c]);
            1:       return longint'(ovf1[c]);
            default: return longint'(ovf2[c]);
        endcase
    endfunction

    function automatic longint dut_valid(input int k);
        case (k)
            0:       return longint'(ov0);
            1:       return longint'(ov1);
            default: return longint'(ov2);
        endcase
    endfunction

    function automatic longint dut_rdy(input int k);
        case (k)
            0:       return longint'(rdy0);
            1:       return longint'(rdy1);
            default: return longint'(rdy2);
        endcase
    endfunction

    function automatic logic [23:0] px(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int c = 0; c < 3; c++) begin
                m_acc[k][c] = 0;
                m_ovf[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt_o[k] = 0;
            for (int c = 0; c < 3; c++) begin
                m_sum_o[k][c] = 0;
                m_ovf_o[k][c] = 1'b0;
            end
        end
        m_full   = 1'b0;
        m_frozen = 1'b0;
    endtask

    function automatic bit model_rdy();
        return !m_full && !m_frozen && !hold;
    endfunction

    // One falling edge of the reference, using the currently driven inputs.
    task automatic model_step();
        longint lim, s, cmax;
        if (m_full) begin
            if (out_ready) begin
                m_full   = 1'b0;
                m_frozen = hold;
            end
        end else if (m_frozen) begin
            if (!hold) begin
                model_clear();
                m_frozen = 1'b0;
            end
        end else if (hold) begin
            m_frozen = 1'b1;
        end else if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
                lim  = (longint'(1) << accw[k]) - 1;
                cmax = (longint'(1) << cntw[k]) - 1;
                for (int c = 0; c < 3; c++) begin
                    s = m_acc[k][c] + longint'(pixel_in[c*8 +: 8]);
                    if (s > lim) begin
                        m_ovf[k][c] = 1'b1;
                        s = satv[k] ? lim : s - (lim + 1);
                    end
                    m_acc[k][c] = s;
                end
                if (m_cnt[k] < cmax) m_cnt[k]++;
            end
            if (in_last) begin
                for (int k = 0; k < 3; k++) begin
                    m_cnt_o[k] = m_cnt[k];
                    for (int c = 0; c < 3; c++) begin
                        m_sum_o[k][c] = m_acc[k][c];
                        m_ovf_o[k][c] = m_ovf[k][c];
                    end
                end
                model_clear();
                m_full = 1'b1;
            end
        end
    endtask

    task automatic check_ready(input string where);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s.in_ready[%0d]", where, k), dut_rdy(k), longint'(model_rdy()));
    endtask

    task automatic check_outputs(input string where);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s.out_valid[%0d]", where, k), dut_valid(k), longint'(m_full));
            check($sformatf("%s.count[%0d]", where, k), dut_cnt(k), m_cnt_o[k]);
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s.sum[%0d][%0d]", where, k, c), dut_sum(k, c), m_sum_o[k][c]);
                check($sformatf("%s.ovf[%0d][%0d]", where, k, c), dut_ovf(k, c), longint'(m_ovf_o[k][c]));
            end
        end
    endtask

    // Fixed expectations taken straight from the region arithmetic.
    task automatic expect_result(input string tag, input int k, input longint s0, input longint s1,
                                 input longint s2, input longint cnt, input logic [2:0] ovf);
        check({tag, ".sum0"}, dut_sum(k, 0), s0);
        check({tag, ".sum1"}, dut_sum(k, 1), s1);
        check({tag, ".sum2"}, dut_sum(k, 2), s2);
        check({tag, ".count"}, dut_cnt(k), cnt);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s.ovf%0d", tag, c), dut_ovf(k, c), longint'(ovf[c]));
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic cycle(input bit v, input bit l, input logic [23:0] p, input bit h, input bit r);
        pixel_in  = p;
        in_valid  = v;
        in_last   = l;
        hold      = h;
        out_ready = r;
        #1;
        check_ready("cyc");
        @(negedge clk);
        model_step();
        @(posedge clk);
        check_outputs("cyc");
    endtask

    task automatic pulse_reset(input string where);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs({where, ".now"});
        check_ready({where, ".now"});
        @(negedge clk);
        @(posedge clk);
        check_outputs({where, ".held"});
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b0;
        pixel_in  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        hold      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_outputs("por");
        check_ready("por");
        @(posedge clk);
        rst = 1'b1;
        check_outputs("rel");

        // Four pixels (255,0,128), last on the fourth
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 3, px(255, 0, 128), 1'b0, 1'b0);
        expect_result("r4.def", 0, 1020, 0, 512, 4, 3'b000);
        expect_result("r4.sat", 1, 511, 0, 511, 3, 3'b101);
        expect_result("r4.wrap", 2, 508, 0, 0, 3, 3'b101);

        // Backpressure: consumer stalls, offered pixels must not be absorbed
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, px(1, 1, 1), 1'b0, 1'b0);
        expect_result("bp.def", 0, 1020, 0, 512, 4, 3'b000);
        cycle(1'b1, 1'b0, px(50, 50, 50), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, px(3, 4, 5), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, px(3, 4, 5), 1'b0, 1'b0);
        expect_result("bp2.def", 0, 6, 8, 10, 2, 3'b000);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Hold discards the partial region
        cycle(1'b1, 1'b0, px(5, 5, 5), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, px(5, 5, 5), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, px(99, 99, 99), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, px(99, 99, 99), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, px(7, 8, 9), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) expect_result($sformatf("hold%0d", k), k, 7, 8, 9, 1, 3'b000);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Three pixels with ch0 = 255: narrow lanes saturate or wrap
        cycle(1'b1, 1'b0, px(255, 1, 0), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, px(255, 1, 0), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, px(255, 1, 0), 1'b0, 1'b0);
        expect_result("ovf.def", 0, 765, 3, 0, 3, 3'b000);
        expect_result("ovf.sat", 1, 511, 3, 0, 3, 3'b001);
        expect_result("ovf.wrap", 2, 253, 3, 0, 3, 3'b001);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Async reset mid-region, then during FLUSH
        cycle(1'b1, 1'b0, px(20, 20, 20), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, px(20, 20, 20), 1'b0, 1'b0);
        pulse_reset("rst_mid");
        cycle(1'b1, 1'b1, px(1, 2, 3), 1'b0, 1'b0);
        expect_result("rst_mid.def", 0, 1, 2, 3, 1, 3'b000);
        pulse_reset("rst_flush");
        cycle(1'b1, 1'b1, px(1, 2, 3), 1'b0, 1'b0);
        expect_result("rst_flush.def", 0, 1, 2, 3, 1, 3'b000);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [23:0] p;
            for (int c = 0; c < 3; c++)
                p[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 249) == 0) pulse_reset("rnd_rst");
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, p,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
